// File: rtl/mem_access_ctrl.sv
// Bus initiator for the calculator's operand/result memory: serialises store and
// recall requests onto a shared tri-state bus with an explicit turnaround cycle.
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr
);

    localparam int SLOTS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        TURN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [DATA_W-1:0] wdata;
    logic [SLOTS-1:0]  written;

    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // The block only drives the bus while the write strobe is high.
    assign mem_data = mem_we ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_write ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_next = IDLE;
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = TURN;
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave flops, not from req_*.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            written   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            mem_we    <= (state_next == WRITE);
            mem_oe    <= (state_next == RD_ADDR) || (state_next == RD_DATA);
            if (accept) begin
                mem_addr <= req_addr;
            end
            if (state == WRITE) begin
                written[mem_addr] <= 1'b1;
            end
            rsp_valid <= (state == WRITE) || (state == RD_DATA);
            rsp_write <= (state == WRITE);
            rsp_err   <= (state == RD_DATA) && !written[mem_addr];
            if (state == RD_DATA) begin
                rsp_rdata <= written[mem_addr] ? mem_data : '0;
            end
        end
    end

    // Store data is a pure datapath register; the write strobe qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata <= req_wdata;
        end
    end

endmodule
